// File: rtl/imu_pkg.sv
// Shared types for the IMU conditioning path: sample struct, FSM states
// and a 16-bit saturation helper.
package imu_pkg;

   localparam int IMU_WIDTH = 16;

   // One IMU sample, x in the most significant field.
   typedef struct packed {
      logic signed [IMU_WIDTH-1:0] x;
      logic signed [IMU_WIDTH-1:0] y;
      logic signed [IMU_WIDTH-1:0] z;
   } data_t;

   // Filter operating mode.
   typedef enum logic {
      ST_CALIB = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // Clamp a 17-bit signed value into the 16-bit signed range.
   function automatic logic signed [15:0] sat16(input logic signed [16:0] d);
      if (d[16] != d[15]) begin
         sat16 = d[16] ? 16'sh8000 : 16'sh7fff;
      end else begin
         sat16 = d[15:0];
      end
   endfunction

endpackage

// File: rtl/imu_axis_filter.sv
// Single-axis datapath: bias accumulator, stored bias, saturating bias
// subtraction and shift-based exponential moving average.
// Handshake: the parent raises exactly one of i_clear / i_acc / i_run per
// cycle for an accepted action; i_load is only ever raised together with
// i_acc and marks the final calibration sample.
module imu_axis_filter
   import imu_pkg::*;
#(
   parameter int   WIDTH       = IMU_WIDTH,
   parameter int   CALIB_LOG2  = 4,
   parameter int   ALPHA_SHIFT = 2,
   parameter logic BIAS_EN     = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    i_clear,
   input  logic                    i_acc,
   input  logic                    i_load,
   input  logic                    i_run,
   input  logic signed [WIDTH-1:0] i_sample,
   output logic signed [WIDTH-1:0] o_filt_next
);

   localparam int AW = WIDTH + CALIB_LOG2;

   logic signed [AW-1:0]    r_acc;
   logic signed [WIDTH-1:0] r_bias;
   logic signed [WIDTH-1:0] r_filt;

   logic signed [AW-1:0]    w_acc_sum;
   logic signed [WIDTH:0]   w_diff;
   logic signed [WIDTH-1:0] w_corr;
   logic signed [WIDTH:0]   w_delta;
   logic signed [WIDTH:0]   w_step;
   logic signed [WIDTH:0]   w_filt_sum;

   // Clamp a WIDTH+1 bit value into the WIDTH-bit signed range.
   function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [WIDTH:0] d);
      if (d[WIDTH] != d[WIDTH-1]) begin
         sat_w = d[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         sat_w = d[WIDTH-1:0];
      end
   endfunction

   // Datapath: running sum, bias-corrected sample, and next EMA value.
   // The EMA sum always lies between old filt and corr, so its clamp never
   // engages; it only folds the guard bit back into WIDTH bits.
   always_comb begin
      w_acc_sum   = r_acc + {{CALIB_LOG2{i_sample[WIDTH-1]}}, i_sample};
      w_diff      = {i_sample[WIDTH-1], i_sample} - {r_bias[WIDTH-1], r_bias};
      w_corr      = sat_w(w_diff);
      w_delta     = {w_corr[WIDTH-1], w_corr} - {r_filt[WIDTH-1], r_filt};
      w_step      = w_delta >>> ALPHA_SHIFT;
      w_filt_sum  = {r_filt[WIDTH-1], r_filt} + w_step;
      o_filt_next = sat_w(w_filt_sum);
   end

   // Accumulator, bias and filter state; the bias is the floor average,
   // which is simply the upper WIDTH bits of the final sum.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc  <= '0;
         r_bias <= '0;
         r_filt <= '0;
      end else begin
         if (i_clear || i_load) begin
            r_acc <= '0;
         end else if (i_acc) begin
            r_acc <= w_acc_sum;
         end
         if (i_load) begin
            r_bias <= BIAS_EN ? w_acc_sum[AW-1:CALIB_LOG2] : '0;
            r_filt <= '0;
         end else if (i_run) begin
            r_filt <= o_filt_next;
         end
      end
   end

endmodule

// File: rtl/imu_filter.sv
// IMU conditioning stage: calibrates a per-axis zero-g bias, then emits
// bias-corrected, EMA-filtered samples with a one-cycle valid strobe.
// Input handshake: in_valid qualifies in_data for one cycle, no backpressure;
// recal in the same cycle wins and the sample is discarded.
// Output handshake: out_valid is a one-cycle strobe, out_data holds between strobes.
module imu_filter
   import imu_pkg::*;
#(
   parameter int         WIDTH       = IMU_WIDTH,
   parameter int         CALIB_LOG2  = 4,
   parameter int         ALPHA_SHIFT = 2,
   parameter logic [2:0] BIAS_MASK   = 3'b011
) (
   input  logic  clk,
   input  logic  reset_n,
   input  data_t in_data,
   input  logic  in_valid,
   input  logic  recal,
   output data_t out_data,
   output logic  out_valid,
   output logic  calibrated,
   output logic  o_dbg_state
);

   state_t                r_state;
   state_t                w_state_next;
   logic [CALIB_LOG2-1:0] r_count;
   logic [CALIB_LOG2-1:0] w_count_next;
   logic                  w_clear;
   logic                  w_acc_en;
   logic                  w_load;
   logic                  w_run;
   logic                  r_out_valid;
   data_t                 r_out_data;

   logic signed [WIDTH-1:0] w_x_next;
   logic signed [WIDTH-1:0] w_y_next;
   logic signed [WIDTH-1:0] w_z_next;

   // FSM state and calibration sample counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_CALIB;
         r_count <= '0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
      end
   end

   // Next state and per-cycle datapath enables; recal overrides everything.
   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      w_clear      = 1'b0;
      w_acc_en     = 1'b0;
      w_load       = 1'b0;
      w_run        = 1'b0;
      if (recal) begin
         w_clear      = 1'b1;
         w_state_next = ST_CALIB;
         w_count_next = '0;
      end else begin
         case (r_state)
            ST_CALIB: begin
               if (in_valid) begin
                  w_acc_en     = 1'b1;
                  w_count_next = r_count + CALIB_LOG2'(1);
                  if (&r_count) begin
                     w_load       = 1'b1;
                     w_count_next = '0;
                     w_state_next = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               w_run = in_valid;
            end
            default: begin
               w_state_next = ST_CALIB;
               w_count_next = '0;
            end
         endcase
      end
   end

   imu_axis_filter #(
      .WIDTH(WIDTH), .CALIB_LOG2(CALIB_LOG2), .ALPHA_SHIFT(ALPHA_SHIFT), .BIAS_EN(BIAS_MASK[0])
   ) u_axis_x (
      .clk(clk), .reset_n(reset_n), .i_clear(w_clear), .i_acc(w_acc_en), .i_load(w_load),
      .i_run(w_run), .i_sample(in_data.x), .o_filt_next(w_x_next)
   );

   imu_axis_filter #(
      .WIDTH(WIDTH), .CALIB_LOG2(CALIB_LOG2), .ALPHA_SHIFT(ALPHA_SHIFT), .BIAS_EN(BIAS_MASK[1])
   ) u_axis_y (
      .clk(clk), .reset_n(reset_n), .i_clear(w_clear), .i_acc(w_acc_en), .i_load(w_load),
      .i_run(w_run), .i_sample(in_data.y), .o_filt_next(w_y_next)
   );

   imu_axis_filter #(
      .WIDTH(WIDTH), .CALIB_LOG2(CALIB_LOG2), .ALPHA_SHIFT(ALPHA_SHIFT), .BIAS_EN(BIAS_MASK[2])
   ) u_axis_z (
      .clk(clk), .reset_n(reset_n), .i_clear(w_clear), .i_acc(w_acc_en), .i_load(w_load),
      .i_run(w_run), .i_sample(in_data.z), .o_filt_next(w_z_next)
   );

   // Output register: separate from the axis filt so the last result holds
   // through recalibration, when filt itself is cleared.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_out_valid <= w_run;
         if (w_run) begin
            r_out_data.x <= w_x_next;
            r_out_data.y <= w_y_next;
            r_out_data.z <= w_z_next;
         end
      end
   end

   assign out_data    = r_out_data;
   assign out_valid   = r_out_valid;
   assign calibrated  = (r_state == ST_RUN);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imu_filter.sv
// Bench for imu_filter: directed scenarios plus a randomized stretch, all
// checked against a sample-level arithmetic model of the filter.
module tb_imu_filter;
   import imu_pkg::*;

   localparam int         ALPHA = 2;
   localparam logic [2:0] MASK  = 3'b011;

   logic  clk = 1'b0;
   logic  reset_n = 1'b0;
   data_t in_data;
   logic  in_valid;
   logic  recal;
   data_t out_data;
   logic  out_valid;
   logic  calibrated;
   logic  dbg_state;

   imu_filter #(
      .WIDTH(16), .CALIB_LOG2(4), .ALPHA_SHIFT(ALPHA), .BIAS_MASK(MASK)
   ) dut (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .recal(recal),
      .out_data(out_data), .out_valid(out_valid), .calibrated(calibrated), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int n_pulses = 0;

   // Reference model state (plain integers).
   int m_acc[3];
   int m_bias[3];
   int m_filt[3];
   int m_out[3];
   int m_cnt;
   bit m_cal;
   bit m_ov;

   function automatic int fdiv(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic int sat(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic logic [47:0] exp_data();
      return {16'(m_out[0]), 16'(m_out[1]), 16'(m_out[2])};
   endfunction

   task automatic model_reset();
      for (int a = 0; a < 3; a++) begin
         m_acc[a] = 0; m_bias[a] = 0; m_filt[a] = 0; m_out[a] = 0;
      end
      m_cnt = 0; m_cal = 1'b0; m_ov = 1'b0;
   endtask

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus, model update, and output comparison.
   task automatic step(input bit vld, input bit rcl, input int sx, input int sy, input int sz,
                       input string tag);
      int s[3];
      s[0] = sx; s[1] = sy; s[2] = sz;
      in_valid  = vld;
      recal     = rcl;
      in_data.x = 16'(sx);
      in_data.y = 16'(sy);
      in_data.z = 16'(sz);
      @(posedge clk);
      #1;
      m_ov = 1'b0;
      if (rcl) begin
         m_cal = 1'b0; m_cnt = 0;
         for (int a = 0; a < 3; a++) m_acc[a] = 0;
      end else if (vld) begin
         if (!m_cal) begin
            for (int a = 0; a < 3; a++) m_acc[a] += s[a];
            m_cnt++;
            if (m_cnt == 16) begin
               for (int a = 0; a < 3; a++) begin
                  m_bias[a] = MASK[a] ? fdiv(m_acc[a], 16) : 0;
                  m_filt[a] = 0;
                  m_acc[a]  = 0;
               end
               m_cnt = 0; m_cal = 1'b1;
            end
         end else begin
            for (int a = 0; a < 3; a++) begin
               m_filt[a] = m_filt[a] + fdiv(sat(s[a] - m_bias[a]) - m_filt[a], 1 << ALPHA);
               m_out[a]  = m_filt[a];
            end
            m_ov = 1'b1;
         end
      end
      check({tag, ".valid"}, 48'(out_valid), 48'(m_ov));
      check({tag, ".cal"}, 48'(calibrated), 48'(m_cal));
      check({tag, ".state"}, 48'(dbg_state), 48'(m_cal));
      check({tag, ".data"}, out_data, exp_data());
      if (out_valid) n_pulses++;
      in_valid = 1'b0;
      recal    = 1'b0;
   endtask

   function automatic int rnd16();
      return int'($urandom_range(65535)) - 32768;
   endfunction

   int exp2[4] = '{100, 175, 231, 273};

   initial begin
      in_valid = 1'b0;
      recal    = 1'b0;
      in_data  = '0;
      model_reset();

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst.data", out_data, 48'h0);
      check("rst.valid", 48'(out_valid), 48'h0);
      check("rst.cal", 48'(calibrated), 48'h0);
      #2 reset_n = 1'b1;

      // Test 1: calibration on constant samples.
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 100, -100, 16384, "t1");
         if (i == 14) check("t1.cal_before_last", 48'(calibrated), 48'h0);
      end
      check("t1.cal_after_16", 48'(calibrated), 48'h1);

      // Test 2: EMA step response on x, z tracking gravity.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 500, 0, 16384, "t2");
         check("t2.x_curve", 48'(out_data.x), 48'(exp2[i]));
      end
      step(1'b0, 1'b0, 0, 0, 0, "t2.idle");

      // Test 3: bias at negative full scale, sample at positive full scale.
      step(1'b0, 1'b1, 0, 0, 0, "t3.recal");
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, -32768, 0, 0, "t3.cal");
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 32767, 0, 0, "t3.run");
         if (i == 0) check("t3.first_x", 48'(out_data.x), 48'(8191));
         check("t3.no_wrap", 48'(out_data.x[15]), 48'h0);
      end

      // Test 4: back-to-back samples.
      n_pulses = 0;
      for (int i = 0; i < 40; i++) step(1'b1, 1'b0, rnd16(), rnd16(), rnd16(), "t4");
      step(1'b0, 1'b0, 0, 0, 0, "t4.tail");
      check("t4.pulses", 48'(n_pulses), 48'(40));

      // Test 5: recal coincident with a RUN sample.
      step(1'b1, 1'b1, rnd16(), rnd16(), rnd16(), "t5.recal");
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, rnd16(), rnd16(), rnd16(), "t5.cal");
      check("t5.recalibrated", 48'(calibrated), 48'h1);
      step(1'b1, 1'b0, rnd16(), rnd16(), rnd16(), "t5.run");

      // Randomized traffic with occasional recal.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(9) < 7), ($urandom_range(49) == 0),
              rnd16(), rnd16(), rnd16(), "rand");
      end

      // Test 6: async reset mid-calibration.
      step(1'b0, 1'b1, 0, 0, 0, "t6.recal");
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, rnd16(), rnd16(), rnd16(), "t6.cal");
      #2 reset_n = 1'b0;
      #1;
      check("t6.async_data", out_data, 48'h0);
      check("t6.async_valid", 48'(out_valid), 48'h0);
      check("t6.async_cal", 48'(calibrated), 48'h0);
      model_reset();
      #3 reset_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 2000, -3000, 16000, "t6.cal2");
         if (i == 14) check("t6.cal_before_16", 48'(calibrated), 48'h0);
      end
      check("t6.cal_after_16", 48'(calibrated), 48'h1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rnd16(), rnd16(), rnd16(), "t6.run");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
